// File: rtl/shift_deserializer.sv
// Serial-in/parallel-out receiver with a double-buffered, valid/ready output register.
// Words arrive LSB-first or MSB-first; the order is chosen by dir at the first bit of each word.
module shift_deserializer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sin,
    input  logic                       sin_valid,
    input  logic                       frame,
    input  logic                       dir,
    input  logic                       q_ready,
    input  logic                       clr_ovr,
    output logic [WIDTH-1:0]           q,
    output logic                       q_valid,
    output logic                       overrun,
    output logic [$clog2(WIDTH+1)-1:0] bit_cnt
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        RECV
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sr, sr_nxt;
    logic [WIDTH-1:0] q_nxt;
    logic [CW-1:0]    cnt_nxt;
    logic             dir_lat, dir_nxt;
    logic             q_valid_nxt;
    logic             ovr_nxt;
    logic             word_done;

    // One bit into the assembly register in the latched order.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur,
                                                  input logic b,
                                                  input logic msb_first);
        return msb_first ? {cur[WIDTH-2:0], b} : {b, cur[WIDTH-1:1]};
    endfunction

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            sr      <= '0;
            dir_lat <= 1'b0;
            bit_cnt <= '0;
            q       <= '0;
            q_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            state   <= state_nxt;
            sr      <= sr_nxt;
            dir_lat <= dir_nxt;
            bit_cnt <= cnt_nxt;
            q       <= q_nxt;
            q_valid <= q_valid_nxt;
            overrun <= ovr_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        sr_nxt      = sr;
        dir_nxt     = dir_lat;
        cnt_nxt     = bit_cnt;
        q_nxt       = q;
        q_valid_nxt = q_valid;
        ovr_nxt     = overrun;
        word_done   = 1'b0;

        unique case (state)
            IDLE: begin
                if (sin_valid && frame) begin
                    dir_nxt   = dir;
                    sr_nxt    = shift_in(sr, sin, dir);
                    cnt_nxt   = CW'(1);
                    state_nxt = RECV;
                end
            end
            RECV: begin
                // Frame drop abandons the partial word; the output stage is untouched.
                if (!frame) begin
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else if (sin_valid) begin
                    sr_nxt = shift_in(sr, sin, dir_lat);
                    if (bit_cnt == CW'(WIDTH - 1)) begin
                        word_done = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = bit_cnt + CW'(1);
                    end
                end
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase

        if (clr_ovr) begin
            ovr_nxt = 1'b0;
        end

        // Output stage: a completed word needs a free (or freeing) slot, otherwise it is dropped.
        if (word_done) begin
            if (!q_valid || q_ready) begin
                q_nxt       = sr_nxt;
                q_valid_nxt = 1'b1;
            end else begin
                ovr_nxt = 1'b1;
            end
        end else if (q_valid && q_ready) begin
            q_valid_nxt = 1'b0;
        end
    end

endmodule
